// File: rtl/muldiv_unit_if.sv
// Execute-stage bundle between the pipeline and the multiply/divide unit.
// The master drives the decoded instruction; the slave returns HI/LO and status.
interface muldiv_unit_if;
  logic        valid;
  logic [3:0]  alucontrol;
  logic        hien;
  logic        loen;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;

  modport master (
    output valid, alucontrol, hien, loen, srca, srcb,
    input  hi, lo, busy, stall, done
  );

  modport slave (
    input  valid, alucontrol, hien, loen, srca, srcb,
    output hi, lo, busy, stall, done
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit signed MULT/DIV with architectural HI/LO registers.
// One bit per cycle on magnitudes, then a single sign-fixup cycle.
module muldiv_unit (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opnd_q, opnd_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        hien_q, hien_d;
  logic        loen_q, loen_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        accept;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign accept = bus.valid & ~busy_q &
                  ((bus.alucontrol == OP_MULT) | (bus.alucontrol == OP_DIV));

  // Two's-complement negation leaves 0x80000000 as its own unsigned magnitude.
  assign abs_a = bus.srca[31] ? -bus.srca : bus.srca;
  assign abs_b = bus.srcb[31] ? -bus.srcb : bus.srcb;

  // MUL: acc = {partial product, remaining multiplier bits}.
  assign mul_sum = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};

  // DIV: acc = {partial remainder, dividend bits shifting into quotient}.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
  // Divide by zero yields all-ones quotient regardless of operand signs.
  assign quo_fix  = (opnd_q == 32'd0) ? 32'hFFFF_FFFF :
                    (neg_res_q ? -acc_q[31:0] : acc_q[31:0]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hien_d    = hien_q;
    loen_d    = loen_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          is_div_d  = bus.alucontrol[0];
          opnd_d    = bus.alucontrol[0] ? abs_b : abs_a;
          acc_d     = {32'd0, (bus.alucontrol[0] ? abs_a : abs_b)};
          neg_res_d = bus.srca[31] ^ bus.srcb[31];
          neg_rem_d = bus.srca[31];
          hien_d    = bus.hien;
          loen_d    = bus.loen;
          cnt_d     = 5'd0;
          busy_d    = 1'b1;
          state_d   = bus.alucontrol[0] ? DIV : MUL;
        end
      end
      MUL: begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      DIV: begin
        if (!div_diff[32]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
        else               acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          if (hien_q) hi_d = rem_fix;
          if (loen_q) lo_d = quo_fix;
        end else begin
          if (hien_q) hi_d = prod_fix[63:32];
          if (loen_q) lo_d = prod_fix[31:0];
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hien_q    <= 1'b0;
      loen_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hien_q    <= hien_d;
      loen_q    <= loen_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.stall = bus.valid & busy_q & (bus.alucontrol[3:2] == 2'b10);
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected HI/LO are queued at issue and
// compared by a monitor whenever done pulses.
module tb_muldiv_unit;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;
  localparam logic [3:0] OP_ADD  = 4'b0010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_count = 0;
  int   last_done_cyc = 0;
  int   prev_done_cyc = 0;
  logic [63:0] sb[$];

  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: each done pulse retires the oldest expected {hi,lo}.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      logic [63:0] exp;
      done_count++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        check("hi", 64'(bus.hi), 64'(exp[63:32]));
        check("lo", 64'(bus.lo), 64'(exp[31:0]));
        $display("done #%0d at cycle %0d hi=0x%08h lo=0x%08h", done_count, cyc, bus.hi, bus.lo);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic he, input logic le, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    bus.valid = 1'b1; bus.alucontrol = op; bus.srca = a; bus.srcb = b;
    bus.hien = he; bus.loen = le;
    sb.push_back({eh, el});
    $display("issue op=%b a=0x%08h b=0x%08h hien=%0b loen=%0b", op, a, b, he, le);
    @(posedge clk); #1;
    // Scramble operands after the accept edge; the in-flight op must ignore them.
    bus.valid = 1'b0; bus.alucontrol = 4'b0000;
    bus.srca = $urandom; bus.srcb = $urandom;
    bus.hien = 1'($urandom); bus.loen = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_n, output int stall_n);
    int n;
    n = 0; busy_n = 0; stall_n = 0;
    @(negedge clk);
    while (bus.done !== 1'b1 && n < 100) begin
      if (bus.busy === 1'b1) busy_n++;
      if (bus.stall === 1'b1) stall_n++;
      n++;
      @(negedge clk);
    end
    #1;
    check("done_seen", 64'(bus.done), 64'd1);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic he, input logic le, input logic [31:0] eh, input logic [31:0] el,
                       input logic pv, input logic [3:0] pop, input int exp_stall);
    int bn, sn;
    issue(op, a, b, he, le, eh, el);
    bus.valid = pv; bus.alucontrol = pop;
    wait_done(bn, sn);
    check("busy_len", 64'(bn), 64'd33);
    check("stall_len", 64'(sn), 64'(exp_stall));
    check("stall_done_cycle", 64'(bus.stall), 64'd0);
    bus.valid = 1'b0; bus.alucontrol = 4'b0000;
    @(negedge clk);
    check("done_width", 64'(bus.done), 64'd0);
  endtask

  initial begin
    int bn, sn, dc;
    bus.valid = 1'b0; bus.alucontrol = 4'b0000; bus.srca = '0; bus.srcb = '0;
    bus.hien = 1'b0; bus.loen = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    bus.valid = 1'b1; bus.alucontrol = OP_MFHI; #1;
    check("idle_mfhi_stall", 64'(bus.stall), 64'd0);
    // MULT presented with valid=0 must not be accepted.
    bus.valid = 1'b0; bus.alucontrol = OP_MULT; bus.srca = 32'd9; bus.srcb = 32'd9;
    repeat (2) @(negedge clk);
    check("novalid_busy", 64'(bus.busy), 64'd0);
    bus.alucontrol = 4'b0000;

    do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, OP_MFHI, 0);
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, OP_ADD, 0);
    do_op(OP_DIV, 32'h1234_5678, 32'd0, 1'b1, 1'b1, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, OP_MFLO, 0);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 32'h8000_0000, 1'b0, OP_ADD, 0);
    do_op(OP_MULT, 32'h0001_0000, 32'h0001_0000, 1'b1, 1'b1, 32'd1, 32'd0, 1'b1, OP_MFHI, 33);
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'd14, 1'b1, OP_MFLO, 33);
    do_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1, 1'b1, 32'd2, 32'hFFFF_FFF2, 1'b0, OP_MFLO, 0);
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000, 32'd0, 1'b0, OP_ADD, 0);

    // Reset ten cycles into a DIV: op aborted, no write, no done.
    @(negedge clk);
    bus.valid = 1'b1; bus.alucontrol = OP_DIV; bus.srca = 32'd1000; bus.srcb = 32'd3;
    bus.hien = 1'b1; bus.loen = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.alucontrol = 4'b0000;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    dc = done_count;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_count), 64'(dc));
    $display("abort: hi=0x%08h lo=0x%08h busy=%0b", bus.hi, bus.lo, bus.busy);

    do_op(OP_MULT, 32'd3, 32'd4, 1'b1, 1'b1, 32'd0, 32'd12, 1'b0, OP_ADD, 0);
    do_op(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 32'h3FFF_FFFF, 32'd12, 1'b0, OP_ADD, 0);
    do_op(OP_DIV, 32'd100, 32'd7, 1'b0, 1'b0, 32'h3FFF_FFFF, 32'd12, 1'b0, OP_ADD, 0);

    // Back-to-back MULTs: the second is held by stall and accepted at E34.
    issue(OP_MULT, 32'd5, 32'd6, 1'b1, 1'b1, 32'd0, 32'd30);
    bus.valid = 1'b1; bus.alucontrol = OP_MULT; bus.srca = 32'd2; bus.srcb = 32'd2;
    bus.hien = 1'b1; bus.loen = 1'b1;
    sb.push_back({32'd0, 32'd4});
    $display("issue op=%b a=0x%08h b=0x%08h (held)", OP_MULT, 32'd2, 32'd2);
    wait_done(bn, sn);
    check("b2b_busy_len", 64'(bn), 64'd33);
    check("b2b_stall_len", 64'(sn), 64'd33);
    check("b2b_stall_done", 64'(bus.stall), 64'd0);
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.alucontrol = 4'b0000;
    check("b2b_accept", 64'(bus.busy), 64'd1);
    wait_done(bn, sn);
    check("b2b2_busy_len", 64'(bn), 64'd33);
    check("b2b_spacing", 64'(last_done_cyc - prev_done_cyc), 64'd34);

    @(negedge clk);
    check("done_total", 64'(done_count), 64'd13);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
